// File: rtl/parity_serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// parity_serial_tx_pkg
//   Shared definitions for the serial even/odd-parity link (transmitter and
//   far-end checker).
//   - FSM state encodings (2-bit, kept as plain constants so the checker and
//     older code can compare against them directly).
//   - Default frame width.
//   - Helper to size the per-frame bit counter.
// ---------------------------------------------------------------------------
package parity_serial_tx_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    // Frames are at least 2 bits wide, so this is never zero.
    function automatic int count_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/parity_serial_tx_acc.sv
// ---------------------------------------------------------------------------
// parity_acc
//   One-bit toggle accumulator used to build a parity bit incrementally.
//   Ports:
//     clock       in  1  rising-edge clock
//     reset_n     in  1  synchronous active-low reset, clears acc
//     load        in  1  overwrite acc with load_value (wins over enable)
//     load_value  in  1  seed value (ODD_PARITY for the transmitter)
//     enable      in  1  fold toggle_in into acc this edge
//     toggle_in   in  1  bit to XOR into acc
//     acc         out 1  accumulated parity, registered
// ---------------------------------------------------------------------------
module parity_acc (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic load_value,
    input  logic enable,
    input  logic toggle_in,
    output logic acc
);

    logic acc_reg;
    logic acc_next;

    always_comb begin
        acc_next = acc_reg;
        if (load) begin
            acc_next = load_value;
        end else if (enable) begin
            acc_next = acc_reg ^ toggle_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/parity_serial_tx.sv
// ---------------------------------------------------------------------------
// parity_serial_tx
//   Serial transmitter for the even/odd-parity link. Takes a parallel word
//   over valid/ready, shifts it out LSB-first one bit per clock, then sends
//   one parity bit. A new word may be accepted during the parity cycle, so
//   frames can run back-to-back with no idle gap.
//   Parameters:
//     WIDTH       data bits per frame (>= 2)
//     ODD_PARITY  0: frame popcount incl. parity is even, 1: odd
//   Ports:
//     clock      in  1      rising-edge clock
//     reset_n    in  1      synchronous active-low reset
//     data_in    in  WIDTH  word to send, captured on accept
//     valid_in   in  1      producer offers data_in
//     ready_out  out 1      word can be accepted this cycle
//     out        out 1      serial line
//     out_valid  out 1      out carries a frame bit
//     out_last   out 1      out carries the parity bit
//     busy       out 1      frame in progress
// ---------------------------------------------------------------------------
module parity_serial_tx
    import parity_serial_tx_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             out,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = count_bits(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    logic out_reg;
    logic out_next;
    logic out_valid_reg;
    logic out_valid_next;
    logic out_last_reg;
    logic out_last_next;
    logic busy_reg;

    logic accept;
    logic acc_load;
    logic acc_enable;
    logic acc_value;

    // Right shift by one, zero fill at the top.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shreg_shifted[gi] = shreg_reg[gi + 1];
        end
    endgenerate
    assign shreg_shifted[WIDTH-1] = 1'b0;

    // Ready in IDLE and during the parity bit; held low in reset.
    assign ready_out = reset_n && ((state_reg == S_IDLE) || (state_reg == S_PARITY));
    assign accept    = valid_in && ready_out;

    // The line outputs are registered, so each branch computes what the line
    // must carry in the cycle after this edge.
    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        count_next     = count_reg;
        out_next       = 1'b0;
        out_valid_next = 1'b0;
        out_last_next  = 1'b0;
        acc_load       = 1'b0;
        acc_enable     = 1'b0;

        case (state_reg)
            S_DATA: begin
                // Bit currently on the line is shreg_reg[0]; fold it in.
                acc_enable     = 1'b1;
                shreg_next     = shreg_shifted;
                out_valid_next = 1'b1;
                if (count_reg == LAST_COUNT) begin
                    state_next    = S_PARITY;
                    count_next    = '0;
                    // acc has not absorbed the last data bit yet.
                    out_next      = acc_value ^ shreg_reg[0];
                    out_last_next = 1'b1;
                end else begin
                    count_next = count_reg + CW'(1);
                    out_next   = shreg_shifted[0];
                end
            end

            default: begin
                // IDLE, PARITY and any unreachable encoding: accept or idle.
                if (accept) begin
                    state_next     = S_DATA;
                    shreg_next     = data_in;
                    count_next     = '0;
                    acc_load       = 1'b1;
                    out_next       = data_in[0];
                    out_valid_next = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            shreg_reg     <= '0;
            count_reg     <= '0;
            out_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            count_reg     <= count_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            busy_reg      <= (state_next != S_IDLE);
        end
    end

    parity_acc u_acc (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (acc_load),
        .load_value (ODD_PARITY),
        .enable     (acc_enable),
        .toggle_in  (shreg_reg[0]),
        .acc        (acc_value)
    );

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

endmodule
